// File: rtl/beat_sequencer.sv
// beat_sequencer: record/playback controller for the beat recorder's two RAM slots.
module beat_sequencer #(
    parameter int ADDR_W   = 8,
    parameter int DATA_W   = 7,
    parameter int TICK_DIV = 2500000
) (
    input  logic              CLOCK_50,
    input  logic              reset,
    input  logic              rec_start,
    input  logic              play_start,
    input  logic              stop,
    input  logic              slot_sel,
    input  logic [DATA_W-1:0] key_ascii,
    output logic [ADDR_W-1:0] ramA_addr,
    output logic              ramA_wren,
    output logic [DATA_W-1:0] ramA_data,
    input  logic [DATA_W-1:0] ramA_q,
    output logic [ADDR_W-1:0] ramB_addr,
    output logic              ramB_wren,
    output logic [DATA_W-1:0] ramB_data,
    input  logic [DATA_W-1:0] ramB_q,
    output logic [DATA_W-1:0] play_note,
    output logic              play_valid,
    output logic [1:0]        state,
    output logic [ADDR_W:0]   lenA,
    output logic [ADDR_W:0]   lenB
);
    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    typedef enum logic [1:0] {IDLE, RECORD, PLAY, FETCH} seqState;

    seqState           cur;
    logic              slot;
    logic [ADDR_W-1:0] wrPtr, rdPtr, addr;
    logic [CW-1:0]     tickCnt;
    logic [ADDR_W:0]   curLen, wrNext, rdNext;
    logic              tick, wren, active;
    logic [DATA_W-1:0] q;

    always_comb begin
        active = cur != IDLE;
        tick = active && tickCnt == CW'(TICK_DIV - 1);
        wren = cur == RECORD && tick;
        addr = cur == RECORD ? wrPtr : rdPtr;
        curLen = slot ? lenB : lenA;
        wrNext = {1'b0, wrPtr} + 1'b1;
        rdNext = {1'b0, rdPtr} + 1'b1;
        q = slot ? ramB_q : ramA_q;
        ramA_addr = active && !slot ? addr : '0;
        ramA_wren = !slot && wren;
        ramA_data = active && !slot ? key_ascii : '0;
        ramB_addr = active && slot ? addr : '0;
        ramB_wren = slot && wren;
        ramB_data = active && slot ? key_ascii : '0;
    end

    assign state = cur;

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            cur <= IDLE;
            slot <= 1'b0;
            wrPtr <= '0;
            rdPtr <= '0;
            tickCnt <= '0;
            lenA <= '0;
            lenB <= '0;
            play_note <= '0;
            play_valid <= 1'b0;
        end else begin
            tickCnt <= (cur == IDLE || tick) ? '0 : tickCnt + 1'b1;
            case (cur)
                IDLE: begin
                    if (rec_start) begin
                        cur <= RECORD;
                        slot <= slot_sel;
                        wrPtr <= '0;
                        if (slot_sel) lenB <= '0;
                        else lenA <= '0;
                    end else if (play_start && (slot_sel ? lenB : lenA) != '0) begin
                        cur <= PLAY;
                        slot <= slot_sel;
                        rdPtr <= '0;
                    end
                end
                RECORD: begin
                    if (tick) begin
                        wrPtr <= wrPtr + 1'b1;
                        if (slot) lenB <= wrNext;
                        else lenA <= wrNext;
                    end
                    // A write on the last address fills the slot and ends recording.
                    if (stop || (tick && &wrPtr)) begin
                        cur <= IDLE;
                        tickCnt <= '0;
                    end
                end
                PLAY: begin
                    if (tick) cur <= FETCH;
                end
                FETCH: begin
                    play_note <= q;
                    play_valid <= 1'b1;
                    rdPtr <= rdNext == curLen ? '0 : rdPtr + 1'b1;
                    cur <= PLAY;
                end
            endcase
            if (stop && (cur == PLAY || cur == FETCH)) begin
                cur <= IDLE;
                tickCnt <= '0;
                play_note <= '0;
                play_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_beat_sequencer.sv
// tb_beat_sequencer: randomized scenario bench for beat_sequencer against a slot-level reference model.
module tb_beat_sequencer;
    localparam int TD = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b0, rec_start = 1'b0, play_start = 1'b0, stop = 1'b0, slot_sel = 1'b0;
    logic [6:0] key_ascii = '0;
    logic [2:0] ramA_addr, ramB_addr;
    logic       ramA_wren, ramB_wren;
    logic [6:0] ramA_data, ramB_data, ramA_q, ramB_q;
    logic [6:0] play_note;
    logic       play_valid;
    logic [1:0] state;
    logic [3:0] lenA, lenB;

    int         tests = 0, fails = 0;
    logic [6:0] expMem[2][8];
    int         expLen[2];
    logic [6:0] memA[8], memB[8];

    beat_sequencer #(.ADDR_W(3), .DATA_W(7), .TICK_DIV(TD)) dut (
        .CLOCK_50(clk), .reset(reset), .rec_start(rec_start), .play_start(play_start),
        .stop(stop), .slot_sel(slot_sel), .key_ascii(key_ascii),
        .ramA_addr(ramA_addr), .ramA_wren(ramA_wren), .ramA_data(ramA_data), .ramA_q(ramA_q),
        .ramB_addr(ramB_addr), .ramB_wren(ramB_wren), .ramB_data(ramB_data), .ramB_q(ramB_q),
        .play_note(play_note), .play_valid(play_valid), .state(state), .lenA(lenA), .lenB(lenB)
    );

    always #5 clk = ~clk;

    // Single-port RAMs with one cycle of read latency.
    always @(posedge clk) begin
        if (ramA_wren) memA[ramA_addr] <= ramA_data;
        if (ramB_wren) memB[ramB_addr] <= ramB_data;
        ramA_q <= memA[ramA_addr];
        ramB_q <= memB[ramB_addr];
    end

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        tests++;
        if (state !== 2'd0) begin fails++; $display("FAIL reset_state: got %0d expected 0", state); end
        tests++;
        if ({lenA, lenB} !== 8'h00) begin fails++; $display("FAIL reset_len: got lenA=%0d lenB=%0d expected 0 0", lenA, lenB); end
        tests++;
        if ({ramA_addr, ramA_wren, ramA_data, ramB_addr, ramB_wren, ramB_data} !== 22'h0) begin
            fails++; $display("FAIL reset_ram: got A=%0h/%0b/%0h B=%0h/%0b/%0h expected all 0",
                ramA_addr, ramA_wren, ramA_data, ramB_addr, ramB_wren, ramB_data);
        end
        tests++;
        if ({play_valid, play_note} !== 8'h00) begin fails++; $display("FAIL reset_play: got valid=%0b note=%0h expected 0 0", play_valid, play_note); end
        expLen[0] = 0;
        expLen[1] = 0;
        @(posedge clk); #1;
    endtask

    // mode 0: run until full, 1: stop one cycle after the last write, 2: stop together with the last write
    task automatic do_record(input bit s, input int n, input int mode, input bit fixedKeys);
        int         lastJ;
        bit         tk;
        logic [6:0] k;
        logic [2:0] ad;
        logic       we;
        logic [6:0] dt;
        logic [10:0] other;
        lastJ = (mode == 1) ? n * TD : n * TD - 1;
        slot_sel = s;
        rec_start = 1'b1;
        @(posedge clk); #1;
        for (int j = 0; j <= lastJ; j++) begin
            tk = (j % TD) == TD - 1;
            k = fixedKeys ? (j < 2 * TD ? 7'h61 : 7'h62) : 7'($urandom_range(1, 127));
            key_ascii = k;
            stop = (mode != 0) && (j == lastJ);
            rec_start = !stop && $urandom_range(0, 3) == 0;
            play_start = !stop && $urandom_range(0, 3) == 0;
            slot_sel = 1'($urandom);
            @(negedge clk);
            ad = s ? ramB_addr : ramA_addr;
            we = s ? ramB_wren : ramA_wren;
            dt = s ? ramB_data : ramA_data;
            other = s ? {ramA_addr, ramA_wren, ramA_data} : {ramB_addr, ramB_wren, ramB_data};
            tests++;
            if (state !== 2'd1) begin fails++; $display("FAIL rec_state j=%0d: got %0d expected 1", j, state); end
            tests++;
            if ({ad, we, dt} !== {3'(j / TD), tk, k}) begin
                fails++; $display("FAIL rec_ram j=%0d: got addr=%0d wren=%0b data=%0h expected addr=%0d wren=%0b data=%0h",
                    j, ad, we, dt, j / TD, tk, k);
            end
            tests++;
            if (other !== 11'h0) begin fails++; $display("FAIL rec_inactive j=%0d: got %0h expected 0", j, other); end
            if (tk) expMem[s][j / TD] = k;
            @(posedge clk); #1;
        end
        {stop, rec_start, play_start} = 3'b000;
        expLen[s] = n;
        @(negedge clk);
        tests++;
        if (state !== 2'd0) begin fails++; $display("FAIL rec_end_state: got %0d expected 0", state); end
        tests++;
        if ((s ? lenB : lenA) !== 4'(n)) begin fails++; $display("FAIL rec_len slot=%0d: got %0d expected %0d", s, s ? lenB : lenA, n); end
        @(posedge clk); #1;
    endtask

    // Plays slot s for nWin cycles; the last cycle carries stop (or reset when viaReset).
    task automatic do_play(input bit s, input int nWin, input bit viaReset);
        int         len, n;
        logic [6:0] k;
        logic [10:0] act, other;
        logic [6:0] expNote;
        len = expLen[s];
        slot_sel = s;
        play_start = 1'b1;
        @(posedge clk); #1;
        play_start = 1'b0;
        for (int j = 0; j < nWin; j++) begin
            k = 7'($urandom);
            key_ascii = k;
            stop = !viaReset && j == nWin - 1;
            reset = viaReset && j == nWin - 1;
            slot_sel = 1'($urandom);
            @(negedge clk);
            n = (j == 0) ? 0 : (j - 1) / TD;
            expNote = n > 0 ? expMem[s][(n - 1) % len] : 7'h0;
            act = s ? {ramB_addr, ramB_wren, ramB_data} : {ramA_addr, ramA_wren, ramA_data};
            other = s ? {ramA_addr, ramA_wren, ramA_data} : {ramB_addr, ramB_wren, ramB_data};
            tests++;
            if (state !== ((j > 0 && j % TD == 0) ? 2'd3 : 2'd2)) begin
                fails++; $display("FAIL play_state j=%0d: got %0d expected %0d", j, state, (j > 0 && j % TD == 0) ? 3 : 2);
            end
            tests++;
            if (act !== {3'(n % len), 1'b0, k}) begin
                fails++; $display("FAIL play_ram j=%0d: got %0h expected addr=%0d wren=0 data=%0h", j, act, n % len, k);
            end
            tests++;
            if (other !== 11'h0) begin fails++; $display("FAIL play_inactive j=%0d: got %0h expected 0", j, other); end
            tests++;
            if ({play_valid, play_note} !== {n > 0, expNote}) begin
                fails++; $display("FAIL play_note j=%0d: got valid=%0b note=%0h expected valid=%0b note=%0h",
                    j, play_valid, play_note, n > 0, expNote);
            end
            @(posedge clk); #1;
        end
        {stop, reset} = 2'b00;
        if (viaReset) begin
            expLen[0] = 0;
            expLen[1] = 0;
        end
        @(negedge clk);
        tests++;
        if ({state, play_valid, play_note} !== 10'h0) begin
            fails++; $display("FAIL play_end: got state=%0d valid=%0b note=%0h expected 0 0 0", state, play_valid, play_note);
        end
        tests++;
        if ({ramA_addr, ramA_wren, ramA_data, ramB_addr, ramB_wren, ramB_data} !== 22'h0) begin
            fails++; $display("FAIL play_end_ram: got A=%0h B=%0h expected 0 0",
                {ramA_addr, ramA_wren, ramA_data}, {ramB_addr, ramB_wren, ramB_data});
        end
        tests++;
        if (lenA !== 4'(expLen[0]) || lenB !== 4'(expLen[1])) begin
            fails++; $display("FAIL play_end_len: got %0d %0d expected %0d %0d", lenA, lenB, expLen[0], expLen[1]);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_record_a();
        do_record(1'b0, 3, 1, 1'b1);
        tests++;
        if (lenB !== 4'(expLen[1])) begin fails++; $display("FAIL rec_a_lenB: got %0d expected %0d", lenB, expLen[1]); end
    endtask

    task automatic test_play_a();
        do_play(1'b0, 4 * TD + 3, 1'b0);
    endtask

    task automatic test_full_auto_stop();
        do_record(1'b1, 8, 0, 1'b0);
        do_play(1'b1, 9 * TD + $urandom_range(0, 2 * TD), 1'b0);
        tests++;
        if (lenA !== 4'd3) begin fails++; $display("FAIL full_lenA_kept: got %0d expected 3", lenA); end
    endtask

    task automatic test_stop_on_tick();
        int n;
        n = $urandom_range(1, 5);
        do_record(1'b1, n, 2, 1'b0);
        do_play(1'b1, (n + 1) * TD + $urandom_range(1, TD), 1'b0);
    endtask

    task automatic test_ignored();
        stop = 1'b1;
        @(posedge clk); #1;
        stop = 1'b0;
        @(negedge clk);
        tests++;
        if (state !== 2'd0 || lenA !== 4'(expLen[0]) || lenB !== 4'(expLen[1])) begin
            fails++; $display("FAIL idle_stop: got state=%0d lens=%0d/%0d expected 0 %0d/%0d", state, lenA, lenB, expLen[0], expLen[1]);
        end
        @(posedge clk); #1;
        slot_sel = 1'b1;
        {rec_start, play_start} = 2'b11;
        @(posedge clk); #1;
        {rec_start, play_start} = 2'b00;
        @(negedge clk);
        tests++;
        if (state !== 2'd1) begin fails++; $display("FAIL rec_beats_play: got %0d expected 1", state); end
        @(posedge clk); #1;
        stop = 1'b1;
        @(posedge clk); #1;
        stop = 1'b0;
        expLen[1] = 0;
        @(negedge clk);
        tests++;
        if (state !== 2'd0 || lenB !== 4'd0) begin fails++; $display("FAIL early_stop: got state=%0d lenB=%0d expected 0 0", state, lenB); end
        @(posedge clk); #1;
        play_start = 1'b1;
        @(posedge clk); #1;
        play_start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            tests++;
            if (state !== 2'd0) begin fails++; $display("FAIL play_empty i=%0d: got %0d expected 0", i, state); end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid_play();
        do_play(1'b0, $urandom_range(2 * TD, 4 * TD), 1'b1);
    endtask

    initial begin
        test_reset();
        test_record_a();
        test_play_a();
        test_full_auto_stop();
        test_stop_on_tick();
        test_ignored();
        test_reset_mid_play();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/beat_sequencer.md
Name: beat_sequencer

Overview:
- Controller that sequences the two recording RAMs (slot A, slot B) of the beat recorder.
- Records: samples the decoded keyboard ASCII code into the selected RAM once per sample tick.
- Plays back: reads the selected slot at the same tick rate and loops over the recorded length.
- Drives the shared RAM address/wren/data lines, replacing the separate store/load counters and muxes, and feeds a playback note to the buzzer rate divider.

Parameters:
- ADDR_W, 8: RAM address width; slot depth = 2^ADDR_W.
- DATA_W, 7: note (ASCII) width.
- TICK_DIV, 2500000: CLOCK_50 cycles per sample tick (50 ms).

Ports:
- CLOCK_50  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- rec_start  in  1  one-cycle pulse: begin recording into slot_sel.
- play_start  in  1  one-cycle pulse: begin looped playback of slot_sel.
- stop  in  1  one-cycle pulse: end recording or playback.
- slot_sel  in  1  0 = slot A, 1 = slot B; sampled only on an accepted start.
- key_ascii  in  DATA_W  current key code; 0 = silence.
- ramA_addr  out  ADDR_W  RAM A address.
- ramA_wren  out  1  RAM A write enable.
- ramA_data  out  DATA_W  RAM A write data.
- ramA_q  in  DATA_W  RAM A read data.
- ramB_addr, ramB_wren, ramB_data, ramB_q: as for A, for RAM B.
- play_note  out  DATA_W  note currently played back.
- play_valid  out  1  high while play_note is meaningful.
- state  out  2  0 IDLE, 1 RECORD, 2 PLAY, 3 FETCH (for LEDG).
- lenA  out  ADDR_W+1  samples stored in slot A (0..2^ADDR_W).
- lenB  out  ADDR_W+1  samples stored in slot B.

Behaviour:
- Reset: state IDLE; lenA = lenB = 0; write pointer, read pointer and tick counter 0; all RAM outputs 0; play_note 0; play_valid 0. Reset overrides every other input, including mid-record and mid-play.
- Tick counter:
  - Counts 0..TICK_DIV-1 and wraps.
  - Cleared to 0 on the cycle a start is accepted.
  - tick is asserted when count == TICK_DIV-1, so the first tick arrives TICK_DIV cycles after the start pulse.
  - Counter holds at 0 in IDLE.
- Inactive slot RAM: addr 0, wren 0, data 0. Active slot data output always = key_ascii.
- IDLE:
  - rec_start → RECORD; latch the slot; that slot's len := 0; wr_ptr := 0.
  - play_start with len(slot_sel) != 0 → PLAY; rd_ptr := 0.
  - play_start with len(slot_sel) == 0 → ignored; stay IDLE.
  - rec_start and play_start in the same cycle: rec_start wins.
  - stop in IDLE: no effect.
- RECORD:
  - addr = wr_ptr.
  - On tick: wren = 1 for exactly that cycle; data = key_ascii; wr_ptr++; len := wr_ptr+1.
  - After the write at address 2^ADDR_W-1: len = 2^ADDR_W; → IDLE automatically (full).
  - stop → IDLE; len keeps the count of completed writes.
  - stop coincident with tick: the write still happens and is counted, then → IDLE.
  - rec_start and play_start are ignored.
- PLAY:
  - addr = rd_ptr, wren 0.
  - On tick → FETCH (RAM read latency is 1 cycle).
- FETCH (1 cycle):
  - play_note := ram_q of the active slot; play_valid := 1.
  - rd_ptr := (rd_ptr+1 == len) ? 0 : rd_ptr+1 (loop).
  - → PLAY.
- stop in PLAY or FETCH → IDLE, with priority over tick and capture; play_note := 0; play_valid := 0.
- play_valid is 0 from play start until the first FETCH completes.
- Re-recording a slot discards its previous contents logically (len reset); RAM contents are not cleared.
- Lengths of both slots persist across operations on the other slot.

Test Plan (bench uses TICK_DIV = 4):
- Reset: assert reset 2 cycles → state 0, lenA = lenB = 0, all RAM wren 0, play_note 0, play_valid 0.
- Record A:
  - Stimulus: rec_start with slot_sel = 0, key_ascii = 0x61 then 0x62, stop after the 3rd tick.
  - Required: ramA_wren pulses at cycles 4, 8, 12 with addr 0, 1, 2 and data 0x61, 0x61, 0x62; lenA = 3; ramB never written.
- Play A (after the Record A scenario):
  - Stimulus: play_start with slot_sel = 0; RAM model returns the stored values.
  - Required: play_note sequence 0x61, 0x61, 0x62, 0x61… with reads from addr 0, 1, 2, 0; play_valid rises one cycle after the first tick.
  - Then stop → play_note 0, state 0.
- Full auto-stop (ADDR_W = 3): record slot B without stop → 8 writes to addr 0..7, then state 0 and lenB = 8.
- Ignored commands:
  - play_start on an empty slot → state stays 0.
  - rec_start + play_start in the same cycle → RECORD.
  - play_start during RECORD → no effect.
- Corner cases:
  - stop on the same cycle as tick in RECORD → write happens and len includes it.
  - reset during PLAY → all outputs return to reset values on the next edge; lenA = 0.
